// File: rtl/speck_pkg.sv
// Shared definitions for the iterative SPECK core.
// Holds the FSM state encoding, width-generic rotate helpers, rotation-amount selection
// and the legal (word, key words) -> round count table used to reject bad configurations.
package speck_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StExpand = 3'd1,
    StEnc    = 3'd2,
    StDec    = 3'd3,
    StDone   = 3'd4
  } state_e;

  // Low w bits set; words are carried in 64-bit containers.
  function automatic logic [63:0] word_mask(int unsigned w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] ror(logic [63:0] x, int unsigned r, int unsigned w);
    logic [63:0] xm;
    xm = x & word_mask(w);
    return ((xm >> r) | (xm << (w - r))) & word_mask(w);
  endfunction

  function automatic logic [63:0] rol(logic [63:0] x, int unsigned r, int unsigned w);
    logic [63:0] xm;
    xm = x & word_mask(w);
    return ((xm << r) | (xm >> (w - r))) & word_mask(w);
  endfunction

  function automatic int unsigned alpha_of(int unsigned w);
    return (w == 16) ? 7 : 8;
  endfunction

  function automatic int unsigned beta_of(int unsigned w);
    return (w == 16) ? 2 : 3;
  endfunction

  // Returns 0 for an illegal combination.
  function automatic int unsigned rounds_of(int unsigned w, int unsigned m);
    case ({w[7:0], m[3:0]})
      {8'd16, 4'd4}: return 22;
      {8'd24, 4'd3}: return 22;
      {8'd24, 4'd4}: return 23;
      {8'd32, 4'd3}: return 26;
      {8'd32, 4'd4}: return 27;
      {8'd48, 4'd2}: return 28;
      {8'd48, 4'd3}: return 29;
      {8'd64, 4'd2}: return 32;
      {8'd64, 4'd3}: return 33;
      {8'd64, 4'd4}: return 34;
      default:       return 0;
    endcase
  endfunction

endpackage

// File: rtl/speck_round.sv
// Combinational SPECK round plus one key-schedule step.
// Ports:
//   mode_i            0 = encrypt round, 1 = decrypt round
//   x_i, y_i          current state words
//   k_i               round subkey
//   l_i, idx_i        schedule l word and round index for the schedule step
//   x_o, y_o          next state words
//   l_new_o, k_next_o new schedule l word and next subkey
module speck_round
  import speck_pkg::*;
#(
  parameter int unsigned WORD = 64
) (
  input  logic            mode_i,
  input  logic [WORD-1:0] x_i,
  input  logic [WORD-1:0] y_i,
  input  logic [WORD-1:0] k_i,
  input  logic [WORD-1:0] l_i,
  input  logic [WORD-1:0] idx_i,
  output logic [WORD-1:0] x_o,
  output logic [WORD-1:0] y_o,
  output logic [WORD-1:0] l_new_o,
  output logic [WORD-1:0] k_next_o
);

  localparam int unsigned Alpha = alpha_of(WORD);
  localparam int unsigned Beta  = beta_of(WORD);

  function automatic logic [WORD-1:0] rr(logic [WORD-1:0] v, int unsigned r);
    return WORD'(ror(64'(v), r, WORD));
  endfunction

  function automatic logic [WORD-1:0] rl(logic [WORD-1:0] v, int unsigned r);
    return WORD'(rol(64'(v), r, WORD));
  endfunction

  logic [WORD-1:0] x_n, y_n, l_n;

  always_comb begin
    l_n      = (k_i + rr(l_i, Alpha)) ^ idx_i;
    l_new_o  = l_n;
    k_next_o = rl(k_i, Beta) ^ l_n;
    if (!mode_i) begin
      x_n = (rr(x_i, Alpha) + y_i) ^ k_i;
      y_n = rl(y_i, Beta) ^ x_n;
    end else begin
      y_n = rr(x_i ^ y_i, Beta);
      x_n = rl((x_i ^ k_i) - y_n, Alpha);
    end
    x_o = x_n;
    y_o = y_n;
  end

endmodule

// File: rtl/speck_iter_core.sv
// Iterative SPECK encrypt/decrypt core with on-the-fly key schedule and a subkey table
// that is reused for decryption while the key is unchanged.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   signal_start    start request (IDLE only); mode/key/block_in sampled with it
//   mode            0 = encrypt, 1 = decrypt
//   key             {l_{m-2}..l0, k0}
//   block_in        {x, y}
//   block_out       result {x, y}, held until the next completion
//   finished        one-cycle completion pulse
//   busy            high while not IDLE
//   state_response  current FSM state
module speck_iter_core
  import speck_pkg::*;
#(
  parameter int unsigned WORD      = 64,
  parameter int unsigned KEY_WORDS = 2,
  parameter int unsigned ROUNDS    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      signal_start,
  input  logic                      mode,
  input  logic [KEY_WORDS*WORD-1:0] key,
  input  logic [2*WORD-1:0]         block_in,
  output logic [2*WORD-1:0]         block_out,
  output logic                      finished,
  output logic                      busy,
  output logic [2:0]                state_response
);

  localparam int unsigned CntW   = $clog2(ROUNDS);
  localparam int unsigned LDepth = KEY_WORDS - 1;

  if (ROUNDS != rounds_of(WORD, KEY_WORDS)) begin : g_cfg_check
    $error("speck_iter_core: ROUNDS does not match the SPECK table for WORD/KEY_WORDS");
  end

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [WORD-1:0]           x_q, y_q, k_q;
  logic [WORD-1:0]           l_q [LDepth];
  logic [WORD-1:0]           subkey_q [ROUNDS];
  logic                      cache_valid_q;
  logic [KEY_WORDS*WORD-1:0] cache_key_q;
  logic [2*WORD-1:0]         block_out_q;

  logic            last, cache_hit, dec_sel;
  logic [WORD-1:0] k_round, x_n, y_n, l_new, k_next;
  logic [CntW-1:0] dec_idx;

  assign last      = (cnt_q == CntW'(ROUNDS - 1));
  assign cache_hit = cache_valid_q && (key == cache_key_q);
  assign dec_sel   = (state_q == StDec);
  assign dec_idx   = CntW'(ROUNDS - 1) - cnt_q;
  assign k_round   = dec_sel ? subkey_q[dec_idx] : k_q;

  speck_round #(
    .WORD(WORD)
  ) u_round (
    .mode_i  (dec_sel),
    .x_i     (x_q),
    .y_i     (y_q),
    .k_i     (k_round),
    .l_i     (l_q[0]),
    .idx_i   (WORD'(cnt_q)),
    .x_o     (x_n),
    .y_o     (y_n),
    .l_new_o (l_new),
    .k_next_o(k_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (signal_start) begin
          if (!mode)          state_d = StEnc;
          else if (cache_hit) state_d = StDec;
          else                state_d = StExpand;
        end
      end
      StEnc:    if (last) state_d = StDone;
      StExpand: if (last) state_d = StDec;
      StDec:    if (last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    finished       = (state_q == StDone);
    busy           = (state_q != StIdle);
    state_response = state_q;
    block_out      = block_out_q;
  end

  // Round counter: runs 0..T-1 in every working state, cleared on its terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle)                                    cnt_d = '0;
    else if (state_q inside {StEnc, StExpand, StDec})         cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Datapath, key schedule and cache bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= '0;
      y_q           <= '0;
      k_q           <= '0;
      for (int j = 0; j < LDepth; j++) l_q[j] <= '0;
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
      block_out_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (signal_start) begin
            x_q <= block_in[2*WORD-1:WORD];
            y_q <= block_in[WORD-1:0];
            k_q <= key[WORD-1:0];
            for (int j = 0; j < LDepth; j++) l_q[j] <= key[(j+1)*WORD +: WORD];
            // The table is about to be rewritten: invalidate until it holds this key.
            if (!mode || !cache_hit) begin
              cache_valid_q <= 1'b0;
              cache_key_q   <= key;
            end
          end
        end
        StEnc, StExpand: begin
          if (state_q == StEnc) begin
            x_q <= x_n;
            y_q <= y_n;
            if (last) block_out_q <= {x_n, y_n};
          end
          k_q <= k_next;
          for (int j = 0; j < LDepth - 1; j++) l_q[j] <= l_q[j+1];
          l_q[LDepth-1] <= l_new;
          if (last) cache_valid_q <= 1'b1;
        end
        StDec: begin
          x_q <= x_n;
          y_q <= y_n;
          if (last) block_out_q <= {x_n, y_n};
        end
        default: ;
      endcase
    end
  end

  // Subkey table; contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (state_q == StEnc || state_q == StExpand) subkey_q[cnt_q] <= k_q;
  end

endmodule

// File: tb/tb_speck_iter_core.sv
module tb_speck_iter_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         a_start = 1'b0, b_start = 1'b0, mode = 1'b0;
  logic [127:0] key = '0, blk = '0;
  logic [127:0] a_out;
  logic         a_fin, a_busy;
  logic [2:0]   a_st;
  logic [63:0]  b_out;
  logic         b_fin, b_busy;
  logic [2:0]   b_st;

  int checks = 0;
  int errors = 0;

  speck_iter_core #(.WORD(64), .KEY_WORDS(2), .ROUNDS(32)) u_a (
    .clk(clk), .rst_n(rst_n), .signal_start(a_start), .mode(mode), .key(key),
    .block_in(blk), .block_out(a_out), .finished(a_fin), .busy(a_busy),
    .state_response(a_st)
  );

  speck_iter_core #(.WORD(32), .KEY_WORDS(4), .ROUNDS(27)) u_b (
    .clk(clk), .rst_n(rst_n), .signal_start(b_start), .mode(mode), .key(key),
    .block_in(blk[63:0]), .block_out(b_out), .finished(b_fin), .busy(b_busy),
    .state_response(b_st)
  );

  localparam logic [127:0] K128  = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT128 = 128'h6c61766975716520_7469206564616d20;
  localparam logic [127:0] CT128 = 128'ha65d985179783265_7860fedf5c570d18;
  localparam logic [127:0] K64   = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [127:0] PT64  = 128'h3b726574_7475432d;
  localparam logic [127:0] CT64  = 128'h8c6fa548_454e028b;

  // ---------------- reference model (plain SPECK from its definition) ----------------
  function automatic logic [63:0] tmask(int w);
    if (w == 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] tror(logic [63:0] x, int r, int w);
    return ((x >> r) | (x << (w - r))) & tmask(w);
  endfunction

  function automatic logic [63:0] trol(logic [63:0] x, int r, int w);
    return ((x << r) | (x >> (w - r))) & tmask(w);
  endfunction

  function automatic logic [127:0] model(bit dec, int w, int m, int t, logic [127:0] k128,
                                         logic [127:0] b);
    logic [63:0] msk, k, x, y, lnew;
    logic [63:0] l  [0:40];
    logic [63:0] ks [0:40];
    int a, bt;
    a   = (w == 16) ? 7 : 8;
    bt  = (w == 16) ? 2 : 3;
    msk = tmask(w);
    k   = k128[63:0] & msk;
    for (int j = 0; j < m - 1; j++) l[j] = 64'(k128 >> ((j + 1) * w)) & msk;
    for (int i = 0; i < t; i++) begin
      ks[i]       = k;
      lnew        = ((k + tror(l[i], a, w)) & msk) ^ 64'(i);
      k           = trol(k, bt, w) ^ lnew;
      l[i + m - 1] = lnew;
    end
    x = 64'(b >> w) & msk;
    y = b[63:0] & msk;
    if (!dec) begin
      for (int i = 0; i < t; i++) begin
        x = ((tror(x, a, w) + y) & msk) ^ ks[i];
        y = trol(y, bt, w) ^ x;
      end
    end else begin
      for (int i = t - 1; i >= 0; i--) begin
        y = tror(x ^ y, bt, w);
        x = trol(((x ^ ks[i]) - y) & msk, a, w);
      end
    end
    return (128'(x) << w) | 128'(y);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic cur_fin(bit sel);
    return sel ? b_fin : a_fin;
  endfunction
  function automatic logic cur_busy(bit sel);
    return sel ? b_busy : a_busy;
  endfunction
  function automatic logic [2:0] cur_st(bit sel);
    return sel ? b_st : a_st;
  endfunction
  function automatic logic [127:0] cur_out(bit sel);
    return sel ? 128'(b_out) : a_out;
  endfunction

  // Latency = number of edges from the start edge to the edge that samples finished high.
  task automatic run(input bit sel, input bit md, input logic [127:0] k, input logic [127:0] b,
                     input int inj, input logic [127:0] alt, input string name,
                     output logic [127:0] out, output int lat, output bit saw_exp);
    int kk;
    bit busy_ok;
    @(negedge clk);
    mode = md; key = k; blk = b;
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0;
    lat = -1; saw_exp = 1'b0; busy_ok = 1'b1; kk = 0;
    while (lat < 0 && kk < 200) begin
      if (cur_st(sel) == 3'd1) saw_exp = 1'b1;
      if (!cur_busy(sel)) busy_ok = 1'b0;
      if (cur_fin(sel)) lat = kk + 1;
      else begin
        if (inj > 0 && kk == inj) begin
          blk = alt; mode = ~md;
          if (sel) b_start = 1'b1; else a_start = 1'b1;
        end
        if (inj > 0 && kk == inj + 1) begin
          a_start = 1'b0; b_start = 1'b0;
        end
        @(negedge clk);
        kk++;
      end
    end
    a_start = 1'b0; b_start = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout got=no finished want=finished within 200 cycles", name);
    end
    chk({name, "_busy"}, 128'(busy_ok), 128'd1);
    out = cur_out(sel);
    @(negedge clk);
    chk({name, "_one_pulse"}, 128'(cur_fin(sel)), 128'd0);
    chk({name, "_idle"}, 128'(cur_st(sel)), 128'd0);
    chk({name, "_hold"}, cur_out(sel), out);
  endtask

  task automatic txn(input string name, input bit sel, input bit md, input logic [127:0] k,
                     input logic [127:0] b, input logic [127:0] exp, input int exp_lat,
                     input bit exp_x);
    logic [127:0] out;
    int lat;
    bit sx;
    run(sel, md, k, b, 0, '0, name, out, lat, sx);
    chk({name, "_out"}, out, exp);
    chk({name, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({name, "_expand"}, 128'(sx), 128'(exp_x));
  endtask

  typedef struct {
    string        name;
    bit           sel;
    bit           md;
    logic [127:0] k;
    logic [127:0] b;
    logic [127:0] exp;
    int           lat;
    bit           expd;
  } vec_t;

  initial begin
    vec_t         tbl [6];
    logic [127:0] kflip, pool [3], k, b, exp, out;
    logic [127:0] ckey [2];
    bit           cval [2];
    bit           sel, md, sx, hit;
    int           lat, t, w, m;

    kflip = K128 ^ (128'd1 << 77);
    tbl[0] = '{"enc128",      1'b0, 1'b0, K128,  PT128, CT128, 33, 1'b0};
    tbl[1] = '{"dec128_hit",  1'b0, 1'b1, K128,  CT128, PT128, 33, 1'b0};
    tbl[2] = '{"dec128_flip", 1'b0, 1'b1, kflip, CT128,
               model(1'b1, 64, 2, 32, kflip, CT128), 65, 1'b1};
    tbl[3] = '{"enc64",       1'b1, 1'b0, K64,   PT64,  CT64,  28, 1'b0};
    tbl[4] = '{"dec64_hit",   1'b1, 1'b1, K64,   CT64,  PT64,  28, 1'b0};
    tbl[5] = '{"dec128_miss", 1'b0, 1'b1, K128,  CT128, PT128, 65, 1'b1};

    // Reset state
    #12;
    chk("rst_a_out", a_out, '0);
    chk("rst_a_fin", 128'(a_fin), '0);
    chk("rst_a_busy", 128'(a_busy), '0);
    chk("rst_a_state", 128'(a_st), '0);
    chk("rst_b_out", 128'(b_out), '0);
    chk("rst_b_busy", 128'(b_busy), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold decrypt: table empty, must expand first
    txn("dec128_cold", 1'b0, 1'b1, K128, CT128, PT128, 65, 1'b1);

    for (int i = 0; i < 6; i++)
      txn(tbl[i].name, tbl[i].sel, tbl[i].md, tbl[i].k, tbl[i].b, tbl[i].exp, tbl[i].lat,
          tbl[i].expd);

    // Randomized traffic with a small key pool so cache hits and misses both occur
    pool[0] = K128;
    pool[1] = {$urandom, $urandom, $urandom, $urandom};
    pool[2] = {$urandom, $urandom, $urandom, $urandom};
    ckey[0] = K128; cval[0] = 1'b1;
    ckey[1] = K64;  cval[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sel = 1'($urandom_range(0, 1));
      md  = 1'($urandom_range(0, 1));
      k   = pool[$urandom_range(0, 2)];
      b   = {$urandom, $urandom, $urandom, $urandom};
      if (sel) begin b = b & 128'hffff_ffff_ffff_ffff; w = 32; m = 4; t = 27; end
      else     begin w = 64; m = 2; t = 32; end
      exp = model(md, w, m, t, k, b);
      hit = cval[sel] && (ckey[sel] == k);
      txn($sformatf("rand%0d", i), sel, md, k, b, exp, (md && !hit) ? 2 * t + 1 : t + 1,
          md && !hit);
      cval[sel] = 1'b1;
      ckey[sel] = k;
    end

    // Start while busy: second request with a different block must be ignored
    run(1'b0, 1'b0, K128, PT128, 5, ~PT128, "busy_start", out, lat, sx);
    chk("busy_start_out", out, CT128);
    chk("busy_start_lat", 128'(lat), 128'd33);

    // Reset in the middle of a (cache-hit) decrypt
    @(negedge clk);
    mode = 1'b1; key = K128; blk = CT128; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("middec_state", 128'(a_st), 128'd3);
    rst_n = 1'b0;
    #1;
    chk("middec_rst_out", a_out, '0);
    chk("middec_rst_fin", 128'(a_fin), '0);
    chk("middec_rst_busy", 128'(a_busy), '0);
    chk("middec_rst_state", 128'(a_st), '0);
    repeat (3) begin
      @(negedge clk);
      chk("middec_no_fin", 128'(a_fin), '0);
    end
    rst_n = 1'b1;
    txn("dec128_after_rst", 1'b0, 1'b1, K128, CT128, PT128, 65, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
